// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register countdown for RAW/WAW,
// mult/div busy countdown for structural hazards, saturating stall counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_BITS = 5,
  parameter int MAX_LAT  = 40,
  parameter int LAT_BITS = 6,
  parameter int ZERO_REG = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                d_valid_i,
  input  logic [REG_BITS-1:0] d_src_a_i,
  input  logic [REG_BITS-1:0] d_src_b_i,
  input  logic                d_use_a_i,
  input  logic                d_use_b_i,
  input  logic [REG_BITS-1:0] d_dest_i,
  input  logic                d_writes_i,
  input  logic [LAT_BITS-1:0] d_lat_i,
  input  logic                d_mdu_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [2:0]          stall_cause_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [31:0]         stall_cycles_o
);

  logic [LAT_BITS-1:0] cnt_q [NUM_REGS];
  logic [LAT_BITS-1:0] cnt_d [NUM_REGS];
  logic [LAT_BITS-1:0] mdu_q, mdu_d;
  logic [31:0]         sc_q, sc_d;

  logic [LAT_BITS-1:0] cnt_a, cnt_b, cnt_w;
  logic [LAT_BITS-1:0] lat_eff, lat_m1;
  logic                raw, waw, strc, act, issue;
  logic                ok_a, ok_b, ok_w;

  // Untracked indices (r0 with ZERO_REG, or beyond NUM_REGS) read as idle.
  assign ok_a = !(ZERO_REG != 0 && d_src_a_i == '0)
             && (32'(d_src_a_i) < 32'(NUM_REGS));
  assign ok_b = !(ZERO_REG != 0 && d_src_b_i == '0)
             && (32'(d_src_b_i) < 32'(NUM_REGS));
  assign ok_w = !(ZERO_REG != 0 && d_dest_i == '0)
             && (32'(d_dest_i) < 32'(NUM_REGS));

  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    cnt_w = '0;
    if (ok_a) cnt_a = cnt_q[d_src_a_i];
    if (ok_b) cnt_b = cnt_q[d_src_b_i];
    if (ok_w) cnt_w = cnt_q[d_dest_i];
  end

  always_comb begin
    lat_eff = d_lat_i;
    if (d_lat_i == '0)
      lat_eff = LAT_BITS'(1);
    else if (d_lat_i > LAT_BITS'(MAX_LAT))
      lat_eff = LAT_BITS'(MAX_LAT);
  end

  assign lat_m1 = lat_eff - LAT_BITS'(1);

  assign raw  = (d_use_a_i && cnt_a != '0)
             || (d_use_b_i && cnt_b != '0);
  assign waw  = d_writes_i && (cnt_w > lat_m1);
  assign strc = d_mdu_i && (mdu_q != '0);
  assign act  = d_valid_i && !flush_i && !rst_i;

  assign stall_cause_o = act ? {strc, waw, raw} : 3'b000;
  assign stall_o       = |stall_cause_o;
  assign issue         = d_valid_i && !flush_i && !stall_o;

  // Issue load overrides the per-cycle decrement of the same entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_BITS'(1) : '0;
      if (issue && d_writes_i && ok_w
          && d_dest_i == REG_BITS'(r))
        cnt_d[r] = lat_m1;
    end
    mdu_d = (mdu_q != '0) ? mdu_q - LAT_BITS'(1) : '0;
    if (issue && d_mdu_i) mdu_d = lat_m1;
    sc_d = sc_q;
    if (stall_o && sc_q != '1) sc_d = sc_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      mdu_q <= '0;
      sc_q  <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      mdu_q <= mdu_d;
      sc_q  <= sc_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      pending_o[r] = (cnt_q[r] != '0);
  end

  assign stall_cycles_o = sc_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected stall/cause per
// cycle is queued by the driver and compared by a negedge monitor.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [4:0]  d_src_a, d_src_b, d_dest;
  logic        d_use_a, d_use_b, d_writes;
  logic [5:0]  d_lat;
  logic        d_mdu, flush;
  logic        stall;
  logic [2:0]  cause;
  logic [31:0] pending;
  logic [31:0] sc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st;
    logic [2:0] ca;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .d_valid_i      (d_valid),
    .d_src_a_i      (d_src_a),
    .d_src_b_i      (d_src_b),
    .d_use_a_i      (d_use_a),
    .d_use_b_i      (d_use_b),
    .d_dest_i       (d_dest),
    .d_writes_i     (d_writes),
    .d_lat_i        (d_lat),
    .d_mdu_i        (d_mdu),
    .flush_i        (flush),
    .stall_o        (stall),
    .stall_cause_o  (cause),
    .pending_o      (pending),
    .stall_cycles_o (sc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, "_stall"}, 32'(stall), 32'(e.st));
      chk({e.tag, "_cause"}, 32'(cause), 32'(e.ca));
    end
  end

  task automatic clr();
    d_valid  = 1'b0;
    d_src_a  = '0;
    d_src_b  = '0;
    d_use_a  = 1'b0;
    d_use_b  = 1'b0;
    d_dest   = '0;
    d_writes = 1'b0;
    d_lat    = '0;
    d_mdu    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic go(input logic st,
                    input logic [2:0] ca,
                    input string tag);
    exp_t e;
    e.st  = st;
    e.ca  = ca;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) go(1'b0, 3'b000, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr();
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pend", pending, 32'd0);
    chk("rst_sc", sc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // load-use: one bubble
    clr();
    d_valid = 1; d_dest = 5; d_writes = 1; d_lat = 2;
    go(1'b0, 3'b000, "ld_issue");
    chk("ld_pend5", 32'(pending[5]), 32'd1);
    clr();
    d_valid = 1; d_src_a = 5; d_use_a = 1;
    d_dest = 6; d_writes = 1; d_lat = 1;
    go(1'b1, 3'b001, "ld_use");
    go(1'b0, 3'b000, "ld_use_go");
    chk("ld_sc", sc, 32'd1);
    chk("ld_pend5_clr", 32'(pending[5]), 32'd0);
    chk("alu_pend6", 32'(pending[6]), 32'd0);

    // ALU back-to-back, lat 0 treated as 1
    clr();
    d_valid = 1; d_dest = 3; d_writes = 1; d_lat = 0;
    go(1'b0, 3'b000, "alu_issue");
    chk("alu_pend3", 32'(pending[3]), 32'd0);
    clr();
    d_valid = 1; d_src_b = 3; d_use_b = 1;
    go(1'b0, 3'b000, "alu_use");
    chk("alu_pend3b", 32'(pending[3]), 32'd0);

    // mult then independent div: 33 struct bubbles
    clr();
    d_valid = 1; d_dest = 4; d_writes = 1;
    d_lat = 34; d_mdu = 1;
    go(1'b0, 3'b000, "mul_issue");
    clr();
    d_valid = 1; d_src_a = 9; d_use_a = 1;
    d_dest = 8; d_writes = 1; d_lat = 34; d_mdu = 1;
    for (int i = 0; i < 33; i++) begin
      chk("mul_pend4", 32'(pending[4]), 32'd1);
      go(1'b1, 3'b100, "div_wait");
    end
    chk("mul_pend4_clr", 32'(pending[4]), 32'd0);
    go(1'b0, 3'b000, "div_issue");
    chk("div_sc", sc, 32'd34);
    idle(40);
    chk("drain_all", pending, 32'd0);

    // WAW: mult r4 then load r4 two cycles later
    clr();
    d_valid = 1; d_dest = 4; d_writes = 1;
    d_lat = 34; d_mdu = 1;
    go(1'b0, 3'b000, "waw_mul");
    idle(1);
    clr();
    d_valid = 1; d_dest = 4; d_writes = 1; d_lat = 2;
    for (int i = 0; i < 31; i++)
      go(1'b1, 3'b010, "waw_wait");
    go(1'b0, 3'b000, "waw_issue");
    chk("waw_sc", sc, 32'd65);
    chk("waw_pend4", 32'(pending[4]), 32'd1);
    idle(5);

    // r0 is never tracked
    clr();
    d_valid = 1; d_dest = 0; d_writes = 1; d_lat = 10;
    go(1'b0, 3'b000, "r0_write");
    chk("r0_pend", 32'(pending[0]), 32'd0);
    clr();
    d_valid = 1; d_src_a = 0; d_use_a = 1;
    d_src_b = 0; d_use_b = 1;
    d_dest = 0; d_writes = 1; d_lat = 1;
    go(1'b0, 3'b000, "r0_read");

    // flush: no stall, no state change, counters kept
    clr();
    d_valid = 1; d_dest = 10; d_writes = 1; d_lat = 21;
    go(1'b0, 3'b000, "r10_issue");
    clr();
    d_valid = 1; flush = 1; d_src_a = 10; d_use_a = 1;
    d_dest = 9; d_writes = 1; d_lat = 5; d_mdu = 1;
    go(1'b0, 3'b000, "flush_rd");
    chk("flush_pend9", 32'(pending[9]), 32'd0);
    chk("flush_pend10", 32'(pending[10]), 32'd1);
    chk("flush_sc", sc, 32'd65);
    clr();
    d_valid = 1; d_dest = 11; d_writes = 1;
    d_lat = 3; d_mdu = 1;
    go(1'b0, 3'b000, "mdu_post_flush");
    clr();
    d_valid = 1; d_src_a = 10; d_use_a = 1;
    go(1'b1, 3'b001, "r10_held");
    chk("held_sc", sc, 32'd66);

    // reset mid-flight with counter[7] = 20
    clr();
    d_valid = 1; d_dest = 7; d_writes = 1; d_lat = 21;
    go(1'b0, 3'b000, "r7_issue");
    clr();
    d_valid = 1; d_src_a = 7; d_use_a = 1;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_cause", 32'(cause), 32'd0);
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_sc", sc, 32'd0);
    #1;
    rst = 1'b0;
    go(1'b0, 3'b000, "post_rst_rd");
    idle(2);
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
